// File: rtl/simon_pkg.sv
// Shared SIMON 64/128 constants, state encoding and word-level helpers.
// Used by both the encrypt and decrypt engines.
package simon_pkg;

    localparam int SIMON_WORD          = 32;
    localparam int SIMON_KEY_WORDS     = 4;
    localparam int SIMON_ROUNDS_64_128 = 44;

    // Z3[j] is the j-th bit of the published z3 sequence, leftmost bit first.
    localparam logic [0:61] Z3 =
        62'b11011011101011000110010111100000010010001010011100110100001111;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_EXPAND = 3'd1,
        S_KEYRDY = 3'd2,
        S_DEC    = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    typedef logic [SIMON_WORD-1:0] word_t;

    function automatic word_t rol(input word_t v, input int unsigned s);
        return (v << s) | (v >> (SIMON_WORD - s));
    endfunction

    function automatic word_t ror(input word_t v, input int unsigned s);
        return (v >> s) | (v << (SIMON_WORD - s));
    endfunction

    function automatic word_t simon_f(input word_t v);
        return (rol(v, 1) & rol(v, 8)) ^ rol(v, 2);
    endfunction

endpackage

// File: rtl/simon_round_inv.sv
// One SIMON inverse round, purely combinational: (x, y, k) -> (y, x ^ f(y) ^ k).
module simon_round_inv
    import simon_pkg::*;
(
    input  logic [SIMON_WORD-1:0] i_x,
    input  logic [SIMON_WORD-1:0] i_y,
    input  logic [SIMON_WORD-1:0] i_k,
    output logic [SIMON_WORD-1:0] o_x,
    output logic [SIMON_WORD-1:0] o_y
);

    assign o_x = i_y;
    assign o_y = i_x ^ simon_f(i_y) ^ i_k;

endmodule

// File: rtl/simon_decrypt_core.sv
// Iterative SIMON 64/128 decryption, one round per clock, with an on-chip key file.
// Key expansion takes 40 cycles after key_load; each block takes 45 cycles from start to out_valid.
module simon_decrypt_core
    import simon_pkg::*;
#(
    parameter int WORD_SIZE = SIMON_WORD,
    parameter int KEY_WORDS = SIMON_KEY_WORDS,
    parameter int ROUNDS    = SIMON_ROUNDS_64_128
) (
    input  logic                           i_clk,
    input  logic                           i_reset,
    input  logic [KEY_WORDS*WORD_SIZE-1:0] i_key_in,
    input  logic                           i_key_load,
    input  logic [2*WORD_SIZE-1:0]         i_data_in,
    input  logic                           i_start,
    output logic                           o_ready,
    output logic                           o_busy,
    output logic                           o_out_valid,
    output logic [2*WORD_SIZE-1:0]         o_data_out
);

    localparam logic [5:0] LAST_IDX = 6'(ROUNDS - 1);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [5:0]             r_idx;
    logic [WORD_SIZE-1:0]   r_x;
    logic [WORD_SIZE-1:0]   r_y;
    logic [2*WORD_SIZE-1:0] r_data_out;
    logic [WORD_SIZE-1:0]   r_kfile [ROUNDS];

    logic                   w_load;
    logic                   w_accept;
    logic [WORD_SIZE-1:0]   w_km1;
    logic [WORD_SIZE-1:0]   w_km3;
    logic [WORD_SIZE-1:0]   w_km4;
    logic [WORD_SIZE-1:0]   w_t0;
    logic [WORD_SIZE-1:0]   w_tmp;
    logic [WORD_SIZE-1:0]   w_knew;
    logic [5:0]             w_zidx;
    logic [WORD_SIZE-1:0]   w_x_nxt;
    logic [WORD_SIZE-1:0]   w_y_nxt;

    // key_load wins over start; both are ignored outside IDLE/KEYRDY
    assign w_load   = i_key_load && (r_state == S_IDLE || r_state == S_KEYRDY);
    assign w_accept = i_start && !i_key_load && (r_state == S_KEYRDY);

    assign w_km1  = r_kfile[r_idx - 6'd1];
    assign w_km3  = r_kfile[r_idx - 6'd3];
    assign w_km4  = r_kfile[r_idx - 6'd4];
    assign w_zidx = r_idx - 6'd4;
    assign w_t0   = ror(w_km1, 3) ^ w_km3;
    assign w_tmp  = w_t0 ^ ror(w_t0, 1);
    assign w_knew = ~w_km4 ^ w_tmp ^ {{(WORD_SIZE-1){1'b0}}, Z3[w_zidx]} ^ WORD_SIZE'(3);

    simon_round_inv u_round (
        .i_x (r_x),
        .i_y (r_y),
        .i_k (r_kfile[r_idx]),
        .o_x (w_x_nxt),
        .o_y (w_y_nxt)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_load) w_state_nxt = S_EXPAND;
            S_EXPAND: if (r_idx == LAST_IDX) w_state_nxt = S_KEYRDY;
            S_KEYRDY: begin
                if (w_load) begin
                    w_state_nxt = S_EXPAND;
                end else if (w_accept) begin
                    w_state_nxt = S_DEC;
                end
            end
            S_DEC:    if (r_idx == 6'd0) w_state_nxt = S_DONE;
            S_DONE:   w_state_nxt = S_KEYRDY;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_idx      <= '0;
            r_x        <= '0;
            r_y        <= '0;
            r_data_out <= '0;
        end else begin
            if (w_load) begin
                r_idx <= 6'd4;
            end else if (w_accept) begin
                r_idx <= LAST_IDX;
                r_x   <= i_data_in[2*WORD_SIZE-1:WORD_SIZE];
                r_y   <= i_data_in[WORD_SIZE-1:0];
            end else if (r_state == S_EXPAND) begin
                r_idx <= r_idx + 6'd1;
            end else if (r_state == S_DEC) begin
                r_x <= w_x_nxt;
                r_y <= w_y_nxt;
                // Capture on the last round so data_out is already valid during DONE
                if (r_idx == 6'd0) begin
                    r_data_out <= {w_x_nxt, w_y_nxt};
                end else begin
                    r_idx <= r_idx - 6'd1;
                end
            end
        end
    end

    // Contents are meaningless until a key has been expanded, so no reset
    always_ff @(posedge i_clk) begin
        if (w_load) begin
            for (int i = 0; i < KEY_WORDS; i++) begin
                r_kfile[i] <= i_key_in[i*WORD_SIZE +: WORD_SIZE];
            end
        end else if (r_state == S_EXPAND) begin
            r_kfile[r_idx] <= w_knew;
        end
    end

    assign o_ready     = (r_state == S_KEYRDY);
    assign o_busy      = (r_state == S_EXPAND) || (r_state == S_DEC) || (r_state == S_DONE);
    assign o_out_valid = (r_state == S_DONE);
    assign o_data_out  = r_data_out;

endmodule

// File: tb/tb_simon_decrypt_core.sv
// Directed and random checks of simon_decrypt_core against a forward SIMON 64/128 model.
module tb_simon_decrypt_core;

    localparam logic [127:0] KEY_PUB = 128'h1b1a1918_13121110_0b0a0908_03020100;
    localparam logic [63:0]  CT_PUB  = 64'h44c8fc20_b9dfa07a;
    localparam logic [63:0]  PT_PUB  = 64'h656b696c_20646e75;
    // z3 packed so that bit j is sequence element j
    localparam logic [61:0]  Z3_LSB  =
        62'b11110000101100111001010001001000000111101001100011010111011011;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [127:0] key_in = '0;
    logic         key_load = 1'b0;
    logic [63:0]  data_in = '0;
    logic         start = 1'b0;
    logic         o_ready, o_busy, o_out_valid;
    logic [63:0]  o_data_out;

    int           checks = 0;
    int           passed = 0;
    int           cyc = 0;
    int           out_cnt = 0;
    logic [63:0]  exp_q[$];
    int           st_q[$];
    int           vcyc_q[$];
    logic [31:0]  ref_k[44];

    simon_decrypt_core dut (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_key_in    (key_in),
        .i_key_load  (key_load),
        .i_data_in   (data_in),
        .i_start     (start),
        .o_ready     (o_ready),
        .o_busy      (o_busy),
        .o_out_valid (o_out_valid),
        .o_data_out  (o_data_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic logic [31:0] trol(input logic [31:0] v, input int s);
        return (v << s) | (v >> (32 - s));
    endfunction

    function automatic logic [31:0] tror(input logic [31:0] v, input int s);
        return (v >> s) | (v << (32 - s));
    endfunction

    function automatic void ref_expand(input logic [127:0] key);
        logic [31:0] t;
        for (int i = 0; i < 4; i++) ref_k[i] = key[32*i +: 32];
        for (int i = 4; i < 44; i++) begin
            t = tror(ref_k[i-1], 3) ^ ref_k[i-3];
            t = t ^ tror(t, 1);
            ref_k[i] = ref_k[i-4] ^ t ^ {31'b0, Z3_LSB[i-4]} ^ 32'hFFFF_FFFC;
        end
    endfunction

    function automatic logic [63:0] ref_enc(input logic [63:0] pt);
        logic [31:0] x, y, t;
        x = pt[63:32];
        y = pt[31:0];
        for (int i = 0; i < 44; i++) begin
            t = x;
            x = y ^ ((trol(x, 1) & trol(x, 8)) ^ trol(x, 2)) ^ ref_k[i];
            y = t;
        end
        return {x, y};
    endfunction

    // Scoreboard: every out_valid pops one expected plaintext and its start cycle
    always @(negedge clk) begin
        if (o_out_valid) begin
            out_cnt++;
            vcyc_q.push_back(cyc);
            chk("done_flags", {62'b0, o_busy, o_ready}, 64'b10);
            if (exp_q.size() == 0) begin
                chk("unexpected_out_valid", 64'd1, 64'd0);
            end else begin
                chk("data_out", o_data_out, exp_q.pop_front());
                chk("latency", 64'(cyc - st_q.pop_front()), 64'd45);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic wait_ready(input string tag, input int bound);
        int n = 0;
        while (!o_ready && n < bound) begin
            @(negedge clk);
            n++;
        end
        chk(tag, {63'b0, o_ready}, 64'd1);
    endtask

    // Call just after a negedge; returns at the negedge of the first cycle in KEYRDY
    task automatic load_key(input logic [127:0] key, input bit with_start, input bit start_in_expand);
        int n = 0;
        key_in   = key;
        key_load = 1'b1;
        start    = with_start;
        data_in  = CT_PUB;
        @(negedge clk);
        key_load = 1'b0;
        start    = 1'b0;
        while (o_busy && !o_ready && n < 100) begin
            start = start_in_expand && (n == 5);
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        chk("expand_cycles", 64'(n), 64'd40);
        chk("ready_after_expand", {62'b0, o_ready, o_busy}, 64'b10);
        ref_expand(key);
    endtask

    task automatic do_start(input logic [63:0] ct, input logic [63:0] exp);
        data_in = ct;
        start   = 1'b1;
        exp_q.push_back(exp);
        st_q.push_back(cyc);
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        logic [127:0] kk;
        logic [63:0]  pt;
        int           base;
        int           n;

        // Reset state
        @(negedge clk);
        chk("rst_ready", {63'b0, o_ready}, 64'd0);
        chk("rst_busy", {63'b0, o_busy}, 64'd0);
        chk("rst_out_valid", {63'b0, o_out_valid}, 64'd0);
        chk("rst_data_out", o_data_out, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // start with no key loaded must do nothing
        base = out_cnt;
        data_in = CT_PUB;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (50) @(negedge clk);
        chk("idle_start_outs", 64'(out_cnt - base), 64'd0);
        chk("idle_start_flags", {62'b0, o_ready, o_busy}, 64'b00);

        // Published vector, with a stray start during expansion
        load_key(KEY_PUB, 1'b0, 1'b1);
        do_start(CT_PUB, PT_PUB);
        wait_ready("pub_ready", 60);

        // start during DEC is ignored: exactly one result
        base = out_cnt;
        do_start(CT_PUB, PT_PUB);
        repeat (10) @(negedge clk);
        data_in = 64'hdead_beef_0123_4567;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_ready("dec_start_ready", 60);
        repeat (3) @(negedge clk);
        chk("dec_start_outs", 64'(out_cnt - base), 64'd1);

        // Back-to-back: second start in the cycle ready rises
        do_start(CT_PUB, PT_PUB);
        n = 0;
        while (!o_out_valid && n < 60) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        chk("b2b_ready", {63'b0, o_ready}, 64'd1);
        pt = {$urandom, $urandom};
        do_start(ref_enc(pt), pt);
        wait_ready("b2b_done", 60);
        if (vcyc_q.size() >= 2)
            chk("b2b_gap", 64'(vcyc_q[vcyc_q.size()-1] - vcyc_q[vcyc_q.size()-2]), 64'd46);
        else
            chk("b2b_count", 64'(vcyc_q.size()), 64'd2);

        // key_load and start together: key wins, start dropped, new key in use
        base = out_cnt;
        kk = 128'h0f0e0d0c_0b0a0908_07060504_03020100;
        load_key(kk, 1'b1, 1'b0);
        repeat (5) @(negedge clk);
        chk("kl_start_outs", 64'(out_cnt - base), 64'd0);
        pt = 64'h0011_2233_4455_6677;
        do_start(ref_enc(pt), pt);
        wait_ready("kl_new_key", 60);

        // Random round trips with the key refreshed every few blocks
        for (int i = 0; i < 24; i++) begin
            if (i % 6 == 0) begin
                kk = {$urandom, $urandom, $urandom, $urandom};
                load_key(kk, 1'b0, 1'b0);
            end
            pt = {$urandom, $urandom};
            do_start(ref_enc(pt), pt);
            wait_ready("rt_ready", 60);
        end

        // Reset in the middle of DEC round 20
        load_key(KEY_PUB, 1'b0, 1'b0);
        do_start(CT_PUB, PT_PUB);
        repeat (23) @(negedge clk);
        chk("pre_reset_busy", {63'b0, o_busy}, 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_ready", {63'b0, o_ready}, 64'd0);
        chk("arst_busy", {63'b0, o_busy}, 64'd0);
        chk("arst_out_valid", {63'b0, o_out_valid}, 64'd0);
        chk("arst_data_out", o_data_out, 64'd0);
        exp_q.delete();
        st_q.delete();
        @(negedge clk);
        rst = 1'b0;
        base = out_cnt;
        data_in = CT_PUB;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (50) @(negedge clk);
        chk("post_rst_start_outs", 64'(out_cnt - base), 64'd0);
        chk("post_rst_ready", {63'b0, o_ready}, 64'd0);
        load_key(KEY_PUB, 1'b0, 1'b0);
        do_start(CT_PUB, PT_PUB);
        wait_ready("post_rst_pub", 60);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
